// File: rtl/f1_start_seq_pkg.sv
// -----------------------------------------------------------------------------
// f1_pkg: shared types and constants for the F1 start-light sequencer.
//   state_t   : sequencer states IDLE, FILL, HOLD, OUT, DONE
//   LFSR_SEED : value loaded into the optional hold-randomising LFSR at reset
//   LFSR_TAPS : tap mask for the 8-bit Fibonacci LFSR (taps 8,6,5,4)
//   lfsr_fb() : feedback bit for one LFSR step
// -----------------------------------------------------------------------------
package f1_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    HOLD = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  // Taps 8,6,5,4 counted from 1 map onto bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic lfsr_fb(input logic [7:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/f1_start_seq_if.sv
// -----------------------------------------------------------------------------
// f1_start_seq_if: control/result bundle between the board I/O and the
// start-light sequencer.
//   en, N, trigger, react                      : driven by master (board side)
//   data_out, busy, result_valid, jump_start,
//   react_time                                 : driven by slave (sequencer)
// -----------------------------------------------------------------------------
interface f1_start_seq_if #(
  parameter int WIDTH      = 8,
  parameter int NUM_LIGHTS = 8,
  parameter int RT_WIDTH   = 16
) ();

  logic                  en;
  logic [WIDTH-1:0]      N;
  logic                  trigger;
  logic                  react;
  logic [NUM_LIGHTS-1:0] data_out;
  logic                  busy;
  logic                  result_valid;
  logic                  jump_start;
  logic [RT_WIDTH-1:0]   react_time;

  modport master (
    output en, N, trigger, react,
    input  data_out, busy, result_valid, jump_start, react_time
  );

  modport slave (
    input  en, N, trigger, react,
    output data_out, busy, result_valid, jump_start, react_time
  );

endinterface

// File: rtl/f1_start_seq_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen: prescaler producing a one-cycle tick every N+1 enabled cycles.
//   clk   in  clock
//   rst_n in  async active-low reset (count cleared)
//   en    in  1 = count, 0 = freeze count and suppress tick
//   run   in  0 = hold count at N (sequencer idle), 1 = count down
//   N     in  reload value; tick period is N+1 cycles
//   tick  out high for the cycle in which the count sits at zero
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             run,
  input  logic [WIDTH-1:0] N,
  output logic             tick
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!run) begin
      r_count <= N;
    end else if (en) begin
      r_count <= (r_count == '0) ? N : r_count - 1'b1;
    end
  end

  assign tick = run & en & (r_count == '0);

endmodule

// File: rtl/f1_start_seq.sv
// -----------------------------------------------------------------------------
// f1_start_seq: F1 start-light sequencer with reaction timer.
// On trigger the lamps fill one per prescaler tick, stay lit for a number of
// hold ticks, then go dark; the clock cycles until react are then counted.
// react before lights-out ends the run as a jump start.
//   clk   in  clock
//   rst_n in  async active-low reset
//   bus   slave modport of f1_start_seq_if (en, N, trigger, react in;
//         data_out, busy, result_valid, jump_start, react_time out)
// Build option: define F1_RANDOM_DELAY_EN to add an 8-bit LFSR whose masked
// value extends the hold by 0..HOLD_MASK ticks; otherwise the hold is MIN_HOLD.
// -----------------------------------------------------------------------------
module f1_start_seq
  import f1_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_LIGHTS = 8,
  parameter int MIN_HOLD   = 2,
  parameter int HOLD_MASK  = 7,
  parameter int RT_WIDTH   = 16
) (
  input logic           clk,
  input logic           rst_n,
  f1_start_seq_if.slave bus
);

  localparam int                 HC_W   = 16;
  localparam logic [RT_WIDTH-1:0] RT_MAX = {RT_WIDTH{1'b1}};

  state_t                r_state, w_next;
  logic [NUM_LIGHTS-1:0] r_data, w_data, w_fill;
  logic                  r_jump, w_jump;
  logic [RT_WIDTH-1:0]   r_rt, w_rt;
  logic [HC_W-1:0]       r_hold, w_hold, w_hold_load;
  logic                  w_run, w_tick;

  assign w_run = (r_state == FILL) || (r_state == HOLD) || (r_state == OUT);

  tick_gen #(.WIDTH(WIDTH)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .run   (w_run),
    .N     (bus.N),
    .tick  (w_tick)
  );

`ifdef F1_RANDOM_DELAY_EN
  logic [7:0] r_lfsr;

  // Free-running from reset so the hold length depends on when trigger arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= LFSR_SEED;
    else        r_lfsr <= {r_lfsr[6:0], lfsr_fb(r_lfsr)};
  end

  assign w_hold_load = HC_W'(MIN_HOLD) + HC_W'(r_lfsr & 8'(HOLD_MASK));
`else
  assign w_hold_load = HC_W'(MIN_HOLD);
`endif

  // Shift-in-a-one form also covers NUM_LIGHTS == 1.
  assign w_fill = (r_data << 1) | NUM_LIGHTS'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_jump  <= 1'b0;
      r_rt    <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_next;
      r_data  <= w_data;
      r_jump  <= w_jump;
      r_rt    <= w_rt;
      r_hold  <= w_hold;
    end
  end

  always_comb begin
    w_next = r_state;
    w_data = r_data;
    w_jump = r_jump;
    w_rt   = r_rt;
    w_hold = r_hold;
    unique case (r_state)
      IDLE, DONE: begin
        if (bus.trigger) begin
          w_next = FILL;
          w_data = '0;
          w_jump = 1'b0;
          w_rt   = '0;
        end
      end
      FILL: begin
        // react wins over a coincident tick.
        if (bus.react) begin
          w_next = DONE;
          w_jump = 1'b1;
        end else if (w_tick) begin
          w_data = w_fill;
          if (&w_fill) begin
            w_next = HOLD;
            w_hold = w_hold_load;
          end
        end
      end
      HOLD: begin
        if (bus.react) begin
          w_next = DONE;
          w_jump = 1'b1;
        end else if (w_tick) begin
          if (r_hold == HC_W'(1)) begin
            w_next = OUT;
            w_data = '0;
            w_rt   = '0;
          end else begin
            w_hold = r_hold - 1'b1;
          end
        end
      end
      OUT: begin
        // Count includes the react cycle itself, so react d cycles after
        // lights-out reports d.
        w_rt = (r_rt == RT_MAX) ? r_rt : r_rt + 1'b1;
        if (bus.react) w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign bus.data_out     = r_data;
  assign bus.busy         = w_run;
  assign bus.result_valid = (r_state == DONE);
  assign bus.jump_start   = r_jump;
  assign bus.react_time   = r_rt;

endmodule

// File: tb/tb_f1_start_seq.sv
module tb_f1_start_seq;

  localparam int NL = 8;
  localparam int H  = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic rst4_n;

  always #5 clk = ~clk;

  f1_start_seq_if #(.WIDTH(8), .NUM_LIGHTS(NL), .RT_WIDTH(16)) bus  ();
  f1_start_seq_if #(.WIDTH(8), .NUM_LIGHTS(NL), .RT_WIDTH(4))  bus4 ();

  f1_start_seq #(.WIDTH(8), .NUM_LIGHTS(NL), .MIN_HOLD(H), .HOLD_MASK(7), .RT_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  f1_start_seq #(.WIDTH(8), .NUM_LIGHTS(NL), .MIN_HOLD(H), .HOLD_MASK(7), .RT_WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst4_n),
    .bus   (bus4)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Lamp vector with c lamps lit from the LSB.
  function automatic logic [7:0] lamp_mask(input int c);
    logic [8:0] t;
    t = (9'd1 << c) - 9'd1;
    return t[7:0];
  endfunction

  // Number of lamps lit when react lands d cycles after the trigger edge:
  // lamp k lights at k*p, but a tick on the react edge itself is lost.
  function automatic int lit_before(input int d, input int p);
    int c;
    c = 0;
    for (int k = 1; k <= NL; k++) if (k * p < d) c++;
    return c;
  endfunction

  // One full run: trigger, react d cycles after the trigger edge, check result.
  task automatic run_check(input int n_val, input int d, input string tag);
    int p, lout, rt;
    p = n_val + 1;
    lout = (NL + H) * p;
    bus.N = 8'(n_val);
    bus.trigger = 1'b1;
    cyc(1);
    bus.trigger = 1'b0;
    cyc(d - 1);
    bus.react = 1'b1;
    cyc(1);
    bus.react = 1'b0;
    chk({tag, "_valid"}, 32'(bus.result_valid), 32'd1);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    if (d <= lout) begin
      chk({tag, "_jump"}, 32'(bus.jump_start), 32'd1);
      chk({tag, "_data"}, 32'(bus.data_out), 32'(lamp_mask(lit_before(d, p))));
      chk({tag, "_rt"}, 32'(bus.react_time), 32'd0);
    end else begin
      rt = d - lout;
      if (rt > 65535) rt = 65535;
      chk({tag, "_jump"}, 32'(bus.jump_start), 32'd0);
      chk({tag, "_data"}, 32'(bus.data_out), 32'd0);
      chk({tag, "_rt"}, 32'(bus.react_time), 32'(rt));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int active, lit, exp_rt, d, n_val;
    bus.en = 1'b1;   bus.N = 8'd4;   bus.trigger = 1'b0;  bus.react = 1'b0;
    bus4.en = 1'b1;  bus4.N = 8'd4;  bus4.trigger = 1'b0; bus4.react = 1'b0;
    rst_n = 1'b0;
    rst4_n = 1'b0;
    cyc(3);
    chk("rst_data", 32'(bus.data_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.result_valid), 32'd0);
    chk("rst_jump", 32'(bus.jump_start), 32'd0);
    chk("rst_rt", 32'(bus.react_time), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // react in IDLE is ignored
    bus.react = 1'b1;
    cyc(2);
    bus.react = 1'b0;
    chk("idle_react_valid", 32'(bus.result_valid), 32'd0);
    chk("idle_react_busy", 32'(bus.busy), 32'd0);

    // Reset mid-FILL acts immediately, sequencer idle afterwards
    bus.trigger = 1'b1;
    cyc(1);
    bus.trigger = 1'b0;
    cyc(12);
    chk("midfill_data", 32'(bus.data_out), 32'h03);
    rst_n = 1'b0;
    #1;
    chk("async_rst_data", 32'(bus.data_out), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_valid", 32'(bus.result_valid), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(8);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_data", 32'(bus.data_out), 32'd0);
    chk("post_rst_valid", 32'(bus.result_valid), 32'd0);

`ifdef F1_RANDOM_DELAY_EN
    begin
      int h, cnt, distinct;
      bit seen[16];
      bit ok;
      for (int i = 0; i < 16; i++) seen[i] = 1'b0;
      bus.N = 8'd0;
      for (int r = 0; r < 50; r++) begin
        cyc($urandom_range(0, 7));
        bus.trigger = 1'b1;
        cyc(1);
        bus.trigger = 1'b0;
        cnt = 0;
        while (bus.data_out !== 8'hFF && cnt < 20) begin cyc(1); cnt++; end
        chk("rand_fill_done", 32'(bus.data_out), 32'hFF);
        h = 0;
        while (bus.data_out !== 8'h00 && h < 40) begin cyc(1); h++; end
        ok = (h >= 2) && (h <= 9);
        chk("rand_hold_range", 32'(ok), 32'd1);
        if (h < 16) seen[h] = 1'b1;
        bus.react = 1'b1;
        cyc(1);
        bus.react = 1'b0;
        chk("rand_done_valid", 32'(bus.result_valid), 32'd1);
      end
      distinct = 0;
      for (int i = 0; i < 16; i++) if (seen[i]) distinct++;
      chk("rand_hold_distinct_ge3", 32'(distinct >= 3), 32'd1);
    end
`else
    // Full sequence, checking every cycle; react 7 cycles after lights-out
    bus.N = 8'd4;
    bus.trigger = 1'b1;
    cyc(1);
    bus.trigger = 1'b0;
    for (int j = 1; j <= 56; j++) begin
      cyc(1);
      lit = (j >= 50) ? 0 : ((j / 5 > NL) ? NL : j / 5);
      chk("seq_data", 32'(bus.data_out), 32'(lamp_mask(lit)));
      chk("seq_busy", 32'(bus.busy), 32'd1);
      if (j >= 50) chk("seq_rt_count", 32'(bus.react_time), 32'(j - 50));
    end
    bus.react = 1'b1;
    cyc(1);
    bus.react = 1'b0;
    chk("seq_valid", 32'(bus.result_valid), 32'd1);
    chk("seq_rt", 32'(bus.react_time), 32'd7);
    chk("seq_jump", 32'(bus.jump_start), 32'd0);

    // Results held in DONE; trigger is ignored while busy
    cyc(5);
    chk("done_hold_rt", 32'(bus.react_time), 32'd7);
    chk("done_hold_valid", 32'(bus.result_valid), 32'd1);

    run_check(4, 28, "jump_1F");
    run_check(4, 50, "jump_final_tick");
    run_check(4, 51, "react_1");
    run_check(4, 1, "jump_immediate");

    // en=0 for 12 cycles mid-FILL freezes the lamps; ticks resume afterwards
    bus.N = 8'd4;
    bus.trigger = 1'b1;
    cyc(1);
    bus.trigger = 1'b0;
    active = 0;
    for (int j = 1; j <= 40; j++) begin
      bus.en = (j >= 13 && j <= 24) ? 1'b0 : 1'b1;
      cyc(1);
      if (bus.en) active++;
      lit = (active / 5 > NL) ? NL : active / 5;
      chk("en_pause_data", 32'(bus.data_out), 32'(lamp_mask(lit)));
    end
    bus.en = 1'b1;
    bus.react = 1'b1;
    cyc(1);
    bus.react = 1'b0;
    chk("en_pause_jump", 32'(bus.jump_start), 32'd1);
    chk("en_pause_jump_data", 32'(bus.data_out), 32'h1F);

    // Random runs against the timeline model
    for (int r = 0; r < 30; r++) begin
      n_val = $urandom_range(0, 5);
      d = $urandom_range(1, (NL + H) * (n_val + 1) + 25);
      run_check(n_val, d, "random");
    end

    // Narrow reaction counter saturates
    rst4_n = 1'b1;
    cyc(2);
    bus4.trigger = 1'b1;
    cyc(1);
    bus4.trigger = 1'b0;
    cyc(80);
    exp_rt = (80 - 50 > 15) ? 15 : 80 - 50;
    chk("sat_rt", 32'(bus4.react_time), 32'(exp_rt));
    chk("sat_busy", 32'(bus4.busy), 32'd1);
    bus4.react = 1'b1;
    cyc(1);
    bus4.react = 1'b0;
    chk("sat_valid", 32'(bus4.result_valid), 32'd1);
    chk("sat_rt_done", 32'(bus4.react_time), 32'd15);
    chk("sat_jump", 32'(bus4.jump_start), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
